// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter and execution-step controller. Emits a
//               one-cycle ADVANCE enable for the pipeline registers and
//               supports single-step, free-run, N-step burst, branch
//               redirect, stall and breakpoints on a single clock.
//               Optional feature macro: DEBOUNCE_EN (STEP_KEY debounce of
//               DB_CYC cycles; DB_CYC only exists when the macro is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h00400000,
    parameter int              BURST_W  = 8,
    parameter int              BP_N     = 2,
    parameter int              CNT_W    = 16
`ifdef DEBOUNCE_EN
    ,
    parameter logic [15:0]     DB_CYC   = 16'd50000
`endif
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [1:0]           MODE,
    input  logic                 STEP_KEY,
    input  logic                 TICK,
    input  logic [BURST_W-1:0]   BURST_LEN,
    input  logic                 STALL,
    input  logic                 BR_TAKEN,
    input  logic [PC_W-1:0]      BR_TARGET,
    input  logic [BP_N*PC_W-1:0] BP_ADDR,
    input  logic [BP_N-1:0]      BP_EN,
    output logic [PC_W-1:0]      PC,
    output logic                 ADVANCE,
    output logic                 HALTED,
    output logic [CNT_W-1:0]     STEP_CNT,
    output logic [1:0]           STATE
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_BURST   = 2'd2;
    localparam logic [1:0] c_ST_BREAK   = 2'd3;

    localparam logic [1:0] c_MODE_STEP  = 2'b00;
    localparam logic [1:0] c_MODE_RUN   = 2'b01;
    localparam logic [1:0] c_MODE_BURST = 2'b10;
    localparam logic [1:0] c_MODE_HOLD  = 2'b11;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_halted;
    logic [PC_W-1:0]    r_pc;
    logic               r_adv;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic               r_key_s1;
    logic               r_key_s2;
    logic               r_step_req;
    logic               w_adv_req;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [BP_N-1:0]    w_bp_match;
    logic               w_bp_hit;
    logic [BURST_W-1:0] w_burst_left;
    logic [BURST_W-1:0] w_burst_load;
    logic               w_burst_load_en;
    logic               w_burst_done;

    // Two-flop synchroniser for the asynchronous, active-low pushbutton
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
        end else begin
            r_key_s1 <= STEP_KEY;
            r_key_s2 <= r_key_s1;
        end
    end

`ifdef DEBOUNCE_EN
    logic        r_db_level;
    logic [15:0] r_db_cnt;

    // Accept a new key level only after it has held for DB_CYC cycles; a press is the accepted fall
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
            r_step_req <= 1'b0;
        end else begin
            r_step_req <= 1'b0;
            if (r_key_s2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_CYC - 16'd1) begin
                r_db_level <= r_key_s2;
                r_db_cnt   <= '0;
                r_step_req <= ~r_key_s2;
            end else begin
                r_db_cnt <= r_db_cnt + 16'd1;
            end
        end
    end
`else
    logic r_key_s3;

    // Registered falling-edge detect: one step request per press
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_key_s3   <= 1'b1;
            r_step_req <= 1'b0;
        end else begin
            r_key_s3   <= r_key_s2;
            r_step_req <= r_key_s3 & ~r_key_s2;
        end
    end
`endif

    // Address the PC takes when the pending advance retires
    assign w_pc_nxt = BR_TAKEN ? BR_TARGET : r_pc + PC_W'(4);

    for (genvar gi = 0; gi < BP_N; gi++) begin : g_bp
        assign w_bp_match[gi] = BP_EN[gi] && (BP_ADDR[gi*PC_W +: PC_W] == w_pc_nxt);
    end

    // Breakpoints only stop free-running states; a step out of BREAK is never re-trapped
    assign w_bp_hit = r_adv && (|w_bp_match) &&
                      ((r_state == c_ST_RUN) || (r_state == c_ST_BURST));

    // Burst counter holds issued-but-unretired advances too; subtract the pending one
    assign w_burst_left = r_burst_cnt - BURST_W'(r_adv);
    assign w_burst_done = (r_adv && (r_burst_cnt == BURST_W'(1))) || (r_burst_cnt == '0);
    assign w_burst_load = (BURST_LEN == '0) ? BURST_W'(1) : BURST_LEN;

    // Next-state and advance-request decode
    always_comb begin
        w_state_nxt     = r_state;
        w_adv_req       = 1'b0;
        w_burst_load_en = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_adv_req = r_step_req && (MODE == c_MODE_STEP);
                if (MODE == c_MODE_RUN) begin
                    w_state_nxt = c_ST_RUN;
                end else if ((MODE == c_MODE_BURST) && r_step_req) begin
                    w_state_nxt     = c_ST_BURST;
                    w_burst_load_en = 1'b1;
                end
            end
            c_ST_RUN: begin
                w_adv_req = TICK && (MODE == c_MODE_RUN) && !w_bp_hit;
                if (w_bp_hit) begin
                    w_state_nxt = c_ST_BREAK;
                end else if (MODE != c_MODE_RUN) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_BURST: begin
                w_adv_req = TICK && (MODE == c_MODE_BURST) && !w_bp_hit &&
                            (w_burst_left != '0);
                if (w_bp_hit) begin
                    w_state_nxt = c_ST_BREAK;
                end else if ((MODE != c_MODE_BURST) || w_burst_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_BREAK: begin
                w_adv_req = r_step_req && (MODE != c_MODE_HOLD);
                if (MODE == c_MODE_HOLD) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register with a registered halt flag
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state  <= c_ST_IDLE;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == c_ST_BREAK);
        end
    end

    // Register the pipeline enable; a stalled request is dropped, not queued
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_adv <= 1'b0;
        end else begin
            r_adv <= w_adv_req && !STALL;
        end
    end

    // Retire an advance: move the PC and count it
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_pc       <= RESET_PC;
            r_step_cnt <= '0;
        end else if (r_adv) begin
            r_pc       <= w_pc_nxt;
            r_step_cnt <= r_step_cnt + CNT_W'(1);
        end
    end

    // Burst length: load on entry, count down per retired advance, discard on exit
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_burst_cnt <= '0;
        end else if (w_burst_load_en) begin
            r_burst_cnt <= w_burst_load;
        end else if (w_state_nxt != c_ST_BURST) begin
            r_burst_cnt <= '0;
        end else if (r_adv) begin
            r_burst_cnt <= r_burst_cnt - BURST_W'(1);
        end
    end

    assign PC       = r_pc;
    assign ADVANCE  = r_adv;
    assign HALTED   = r_halted;
    assign STEP_CNT = r_step_cnt;
    assign STATE    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A behavioural model
//               tracks PC, advance, step count and state from the rules
//               (advances left to issue, key sample history); a compare
//               process checks every cycle, and directed scenarios pin
//               literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h00400000;
    localparam int          BURST_W  = 8;
    localparam int          BP_N     = 2;
    localparam int          CNT_W    = 16;

    logic                 CLOCK_50 = 1'b0;
    logic                 RESET;
    logic [1:0]           MODE;
    logic                 STEP_KEY;
    logic                 TICK;
    logic [BURST_W-1:0]   BURST_LEN;
    logic                 STALL;
    logic                 BR_TAKEN;
    logic [PC_W-1:0]      BR_TARGET;
    logic [BP_N*PC_W-1:0] BP_ADDR;
    logic [BP_N-1:0]      BP_EN;
    logic [PC_W-1:0]      PC;
    logic                 ADVANCE;
    logic                 HALTED;
    logic [CNT_W-1:0]     STEP_CNT;
    logic [1:0]           STATE;

    always #5 CLOCK_50 = ~CLOCK_50;

    pc_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .BURST_W  (BURST_W),
        .BP_N     (BP_N),
        .CNT_W    (CNT_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .MODE      (MODE),
        .STEP_KEY  (STEP_KEY),
        .TICK      (TICK),
        .BURST_LEN (BURST_LEN),
        .STALL     (STALL),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .BP_ADDR   (BP_ADDR),
        .BP_EN     (BP_EN),
        .PC        (PC),
        .ADVANCE   (ADVANCE),
        .HALTED    (HALTED),
        .STEP_CNT  (STEP_CNT),
        .STATE     (STATE)
    );

    int n_total = 0;
    int n_pass  = 0;
    int adv_seen = 0;
    bit chk_en = 1'b0;
    int tick_mode = 0;   // 0 off, 1 every 4th cycle, 2 random
    int tick_ph = 0;

    // ---------------- behavioural model ----------------
    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_BURST = 2'd2, M_BREAK = 2'd3;
    logic [31:0] m_pc;
    logic        m_adv;
    logic [15:0] m_cnt;
    logic [1:0]  m_state;
    int          m_left;     // burst advances not yet issued
    logic [3:0]  m_khist;    // [0] newest STEP_KEY sample

    always @(posedge CLOCK_50) begin : p_model
        logic        step, hit, issue;
        logic [31:0] pc_n;
        logic [1:0]  st_n;
        int          left_n;
        if (RESET) begin
            m_pc    <= RESET_PC;
            m_adv   <= 1'b0;
            m_cnt   <= 16'd0;
            m_state <= M_IDLE;
            m_left  <= 0;
            m_khist <= 4'hF;
        end else begin
            // press seen 2 sync + 1 edge stage after the key fell
            step = m_khist[3] & ~m_khist[2];
            pc_n = m_pc;
            hit  = 1'b0;
            if (m_adv) begin
                pc_n = BR_TAKEN ? BR_TARGET : m_pc + 32'd4;
                if (m_state == M_RUN || m_state == M_BURST)
                    for (int i = 0; i < BP_N; i++)
                        if (BP_EN[i] && BP_ADDR[i*PC_W +: PC_W] == pc_n) hit = 1'b1;
            end
            issue  = 1'b0;
            st_n   = m_state;
            left_n = m_left;
            case (m_state)
                M_IDLE: begin
                    issue = step && MODE == 2'b00;
                    if (MODE == 2'b01) st_n = M_RUN;
                    else if (MODE == 2'b10 && step) begin
                        st_n   = M_BURST;
                        left_n = (BURST_LEN == 0) ? 1 : int'(BURST_LEN);
                    end
                end
                M_RUN: begin
                    issue = TICK && MODE == 2'b01 && !hit;
                    if (hit) st_n = M_BREAK;
                    else if (MODE != 2'b01) st_n = M_IDLE;
                end
                M_BURST: begin
                    issue = TICK && MODE == 2'b10 && !hit && m_left > 0;
                    if (issue && !STALL) left_n = m_left - 1;
                    if (hit) begin
                        st_n = M_BREAK; left_n = 0;
                    end else if (MODE != 2'b10 || m_left == 0) begin
                        st_n = M_IDLE; left_n = 0;
                    end
                end
                default: begin
                    issue = step && MODE != 2'b11;
                    if (MODE == 2'b11) st_n = M_IDLE;
                end
            endcase
            m_pc    <= pc_n;
            m_cnt   <= m_adv ? m_cnt + 16'd1 : m_cnt;
            m_adv   <= issue && !STALL;
            m_state <= st_n;
            m_left  <= left_n;
            m_khist <= {m_khist[2:0], STEP_KEY};
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            n_total++;
            if (PC === m_pc && ADVANCE === m_adv && HALTED === (m_state == M_BREAK) &&
                STEP_CNT === m_cnt && STATE === m_state)
                n_pass++;
            else
                $display("FAIL model t=%0t: got pc=%h adv=%b halt=%b cnt=%0d st=%0d, expected pc=%h adv=%b halt=%b cnt=%0d st=%0d",
                         $time, PC, ADVANCE, HALTED, STEP_CNT, STATE,
                         m_pc, m_adv, (m_state == M_BREAK), m_cnt, m_state);
        end
    end

    // Count ADVANCE pulses for directed scenarios
    always @(negedge CLOCK_50) begin
        if (ADVANCE === 1'b1) adv_seen++;
    end

    // Sole driver of TICK
    always begin
        @(posedge CLOCK_50);
        #2;
        tick_ph = (tick_ph + 1) % 4;
        case (tick_mode)
            1:       TICK = (tick_ph == 0);
            2:       TICK = ($urandom_range(0, 2) == 0);
            default: TICK = 1'b0;
        endcase
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc(2);
        RESET = 1'b0;
    endtask

    task automatic press();
        STEP_KEY = 1'b0;
        cyc(3);
        STEP_KEY = 1'b1;
        cyc(5);
    endtask

    task automatic wait_adv(input int target, input string name);
        int k = 0;
        while (adv_seen < target && k < 200) begin
            cyc(1);
            k++;
        end
        check(name, 32'(adv_seen >= target), 32'd1);
    endtask

    int base;
    int k;

    initial begin
        RESET     = 1'b1;
        MODE      = 2'b00;
        STEP_KEY  = 1'b1;
        BURST_LEN = '0;
        STALL     = 1'b0;
        BR_TAKEN  = 1'b0;
        BR_TARGET = '0;
        BP_ADDR   = '0;
        BP_EN     = '0;
        TICK      = 1'b0;

        // reset state
        cyc(2);
        chk_en = 1'b1;
        RESET  = 1'b0;
        check("reset_pc", PC, 32'h00400000);
        check("reset_state", 32'(STATE), 32'd0);
        check("reset_cnt", 32'(STEP_CNT), 32'd0);
        check("reset_adv", 32'(ADVANCE), 32'd0);

        // three manual steps
        base = adv_seen;
        repeat (3) press();
        cyc(2);
        check("step_pulses", 32'(adv_seen - base), 32'd3);
        check("step_pc", PC, 32'h0040000C);
        check("step_cnt", 32'(STEP_CNT), 32'd3);

        // burst of 5
        do_reset();
        MODE = 2'b10; BURST_LEN = 8'd5; tick_mode = 1;
        base = adv_seen;
        press();
        cyc(40);
        check("burst5_pulses", 32'(adv_seen - base), 32'd5);
        check("burst5_state", 32'(STATE), 32'd0);
        check("burst5_pc", PC, 32'h00400014);

        // burst length 0 behaves as 1
        do_reset();
        BURST_LEN = 8'd0;
        base = adv_seen;
        press();
        cyc(20);
        check("burst0_pulses", 32'(adv_seen - base), 32'd1);
        check("burst0_pc", PC, 32'h00400004);
        tick_mode = 0;

        // run with a taken branch on the second advance
        do_reset();
        MODE = 2'b01; BR_TARGET = 32'h00400100; tick_mode = 1;
        base = adv_seen;
        wait_adv(base + 1, "br_wait1");
        BR_TAKEN = 1'b1;
        wait_adv(base + 2, "br_wait2");
        BR_TAKEN = 1'b0;
        check("br_target_pc", PC, 32'h00400100);
        wait_adv(base + 3, "br_wait3");
        check("br_next_pc", PC, 32'h00400104);
        MODE = 2'b11; tick_mode = 0;
        cyc(3);

        // PC wrap to zero
        do_reset();
        MODE = 2'b00; BR_TAKEN = 1'b1; BR_TARGET = 32'hFFFFFFFC;
        press();
        BR_TAKEN = 1'b0;
        check("wrap_top", PC, 32'hFFFFFFFC);
        press();
        check("wrap_zero", PC, 32'h00000000);

        // breakpoint
        do_reset();
        BP_ADDR = {32'h0, 32'h00400008}; BP_EN = 2'b01;
        MODE = 2'b01; tick_mode = 1;
        k = 0;
        while (HALTED !== 1'b1 && k < 200) begin cyc(1); k++; end
        check("bp_halted", 32'(HALTED), 32'd1);
        check("bp_pc", PC, 32'h00400008);
        check("bp_state", 32'(STATE), 32'd3);
        cyc(20);
        check("bp_tick_ignored_pc", PC, 32'h00400008);
        check("bp_tick_ignored_cnt", 32'(STEP_CNT), 32'd2);
        press();
        cyc(2);
        check("bp_step_pc", PC, 32'h0040000C);
        check("bp_step_halted", 32'(HALTED), 32'd1);
        MODE = 2'b11;
        cyc(2);
        check("bp_release_state", 32'(STATE), 32'd0);
        BP_EN = '0; tick_mode = 0;

        // stall drops ticks
        do_reset();
        MODE = 2'b01; STALL = 1'b1; tick_mode = 1;
        base = adv_seen;
        cyc(14);
        check("stall_pulses", 32'(adv_seen - base), 32'd0);
        check("stall_pc", PC, 32'h00400000);
        check("stall_cnt", 32'(STEP_CNT), 32'd0);
        STALL = 1'b0; MODE = 2'b11;
        cyc(2);

        // reset mid-burst
        MODE = 2'b10; BURST_LEN = 8'd20;
        press();
        cyc(10);
        check("midburst_state", 32'(STATE), 32'd2);
        RESET = 1'b1;
        cyc(1);
        check("midburst_rst_pc", PC, 32'h00400000);
        check("midburst_rst_state", 32'(STATE), 32'd0);
        check("midburst_rst_cnt", 32'(STEP_CNT), 32'd0);
        check("midburst_rst_adv", 32'(ADVANCE), 32'd0);
        RESET = 1'b0;
        tick_mode = 0;
        cyc(2);

        // randomized traffic, checked every cycle against the model
        tick_mode = 2;
        BP_ADDR = {RESET_PC + 32'd16, RESET_PC + 32'd28};
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) MODE = 2'($urandom_range(0, 3));
            STALL     = ($urandom_range(0, 3) == 0);
            BR_TAKEN  = ($urandom_range(0, 4) == 0);
            BR_TARGET = ($urandom_range(0, 31) == 0) ? 32'hFFFFFFFC
                                                     : RESET_PC + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0)
                BP_ADDR[$urandom_range(0, 1)*32 +: 32] = RESET_PC + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) BP_EN = 2'($urandom_range(0, 3));
            BURST_LEN = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) STEP_KEY = ~STEP_KEY;
            RESET     = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        RESET = 1'b0;
        tick_mode = 0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
